serializer_10_to_1_7bits: RTL

Sequential 10-to-1 serializer for 7-bit lanes: captures ten parallel values on a single load strobe and streams them out one per beat over a valid/ready handshake, tagging each beat with its 4-bit lane index. Sits at the LeNet5 unit3 output boundary and is the reverse of the 1-to-10 lane distribution: it gathers the ten class/neuron results and hands them to a single-lane consumer, such as a result FIFO, argmax stage or host interface.

---
 rtl/serializer_10_to_1_7bits_if.sv | 36 +++
 rtl/serializer_10_to_1_7bits.sv | 124 ++++++++++++
 2 files changed

// File: rtl/serializer_10_to_1_7bits_if.sv
// rtl/serializer_10_to_1_7bits_if.sv - parallel-load / serial-beat bus for the 10-to-1 serializer
interface serializer_10_to_1_7bits_if #(
   parameter int DATA_WIDTH = 7
);
   logic                  load;
   logic [DATA_WIDTH-1:0] din_1;
   logic [DATA_WIDTH-1:0] din_2;
   logic [DATA_WIDTH-1:0] din_3;
   logic [DATA_WIDTH-1:0] din_4;
   logic [DATA_WIDTH-1:0] din_5;
   logic [DATA_WIDTH-1:0] din_6;
   logic [DATA_WIDTH-1:0] din_7;
   logic [DATA_WIDTH-1:0] din_8;
   logic [DATA_WIDTH-1:0] din_9;
   logic [DATA_WIDTH-1:0] din_10;
   logic [DATA_WIDTH-1:0] dout;
   logic [3:0]            dout_sel;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  busy;
   logic                  done;

   // producer of the parallel lanes and consumer of the serial beats
   modport master (
      output load, din_1, din_2, din_3, din_4, din_5,
             din_6, din_7, din_8, din_9, din_10, dout_ready,
      input  dout, dout_sel, dout_valid, busy, done
   );

   // the serializer itself
   modport slave (
      input  load, din_1, din_2, din_3, din_4, din_5,
             din_6, din_7, din_8, din_9, din_10, dout_ready,
      output dout, dout_sel, dout_valid, busy, done
   );
endinterface

// File: rtl/serializer_10_to_1_7bits.sv
// rtl/serializer_10_to_1_7bits.sv - captures ten lanes on load and streams them out one beat at a time
module serializer_10_to_1_7bits #(
   parameter int DATA_WIDTH = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   serializer_10_to_1_7bits_if.slave bus
);
   localparam int         LANES    = 10;
   localparam logic [3:0] LAST_IDX = 4'd9;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state;
   state_t                state_next;
   logic [3:0]            idx;
   logic [3:0]            idx_next;
   logic                  capture;
   logic                  accept;
   logic                  last;
   logic [DATA_WIDTH-1:0] lanes [LANES];
   logic [DATA_WIDTH-1:0] hold  [LANES];
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  done_q;

   assign lanes[0] = bus.din_1;
   assign lanes[1] = bus.din_2;
   assign lanes[2] = bus.din_3;
   assign lanes[3] = bus.din_4;
   assign lanes[4] = bus.din_5;
   assign lanes[5] = bus.din_6;
   assign lanes[6] = bus.din_7;
   assign lanes[7] = bus.din_8;
   assign lanes[8] = bus.din_9;
   assign lanes[9] = bus.din_10;

   // state and beat index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= 4'd0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // next state: load is only looked at in IDLE, so a load during SEND
   // (including the final acceptance cycle) is silently dropped
   always_comb begin
      state_next = state;
      idx_next   = idx;
      capture    = 1'b0;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load) begin
               capture    = 1'b1;
               idx_next   = 4'd0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (bus.dout_ready) begin
               accept = 1'b1;
               if (idx == LAST_IDX) begin
                  last       = 1'b1;
                  idx_next   = 4'd0;
                  state_next = IDLE;
               end else begin
                  idx_next = idx + 4'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = 4'd0;
         end
      endcase
   end

   // holding register, written only when a load is honoured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            hold[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < LANES; i++) begin
            hold[i] <= lanes[i];
         end
      end
   end

   // registered beat data: first lane straight from the inputs on capture,
   // later lanes from the holding register, zero once the frame ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else if (capture) begin
         dout_q <= lanes[0];
      end else if (last) begin
         dout_q <= '0;
      end else if (accept) begin
         dout_q <= hold[idx_next];
      end
   end

   // end-of-frame pulse, high for the cycle after the tenth acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= last;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_sel   = idx;
   assign bus.dout_valid = (state == SEND);
   assign bus.busy       = (state == SEND);
   assign bus.done       = done_q;
endmodule
